// File: rtl/a_ram_loader.sv
// Writable A-coefficient store: packs a valid/ready stream of coefficients in pairs
// into a register array that reads back in the same packed, addressed format as the A ROM.
module a_ram_loader #(
    parameter int COEF_W   = 7,
    parameter int NUM_COEF = 32,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COEF_W-1:0]     coef_in,
    input  logic                  coef_valid,
    output logic                  coef_ready,
    output logic                  busy,
    output logic                  load_done,
    input  logic [ADDR_W-1:0]     rom_addr,
    output logic [2*COEF_W-1:0]   A_input
);

    localparam int DEPTH = NUM_COEF / 2;
    localparam int CNT_W = $clog2(NUM_COEF);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_COEF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [COEF_W-1:0]     hold;
    logic [2*COEF_W-1:0]   mem [DEPTH];
    logic                  accept;

    // coef_ready is a registered flag, so accept never loops back into coef_ready.
    assign accept = coef_valid && coef_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hold       <= '0;
            coef_ready <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            A_input    <= '0;
            // NOTE: the array is cleared on reset because an abandoned load must not
            // leave a partial matrix behind; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking read and write of the same word in one cycle returns
            // the old value; the new word shows up on the following read.
            A_input <= mem[rom_addr];

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        cnt        <= '0;
                        coef_ready <= 1'b1;
                        busy       <= 1'b1;
                        load_done  <= 1'b0;
                    end
                end

                LOAD: begin
                    if (accept) begin
                        if (!cnt[0]) begin
                            hold <= coef_in;
                        end else begin
                            mem[cnt[CNT_W-1:1]] <= {hold, coef_in};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state      <= DONE;
                            coef_ready <= 1'b0;
                            busy       <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    coef_ready <= 1'b0;
                    busy       <= 1'b0;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a_ram_loader.sv
// Directed bench for a_ram_loader: reset, full load, gaps, ignored inputs,
// reload with read-during-write, and reset mid-load, against a packing model.
module tb_a_ram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  coef_in;
    logic        coef_valid;
    logic        coef_ready;
    logic        busy;
    logic        load_done;
    logic [3:0]  rom_addr;
    logic [13:0] A_input;

    int          vectors = 0;
    int          miscompares = 0;
    logic [13:0] exp_mem [16];
    logic [6:0]  hold_m;

    a_ram_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .busy       (busy),
        .load_done  (load_done),
        .rom_addr   (rom_addr),
        .A_input    (A_input)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic read_word(input logic [3:0] a, output logic [13:0] d);
        rom_addr = a;
        step();
        d = A_input;
    endtask

    // Packing model: even index is held, odd index completes {even, odd}.
    task automatic model_accept(input int idx, input logic [6:0] v);
        if (idx % 2 == 0) hold_m = v;
        else exp_mem[idx / 2] = {hold_m, v};
    endtask

    task automatic test_reset();
        logic [13:0] d;
        rst = 1'b1;
        repeat (2) begin
            start      = 1'($urandom);
            coef_valid = 1'($urandom);
            coef_in    = 7'($urandom);
            rom_addr   = 4'($urandom);
            step();
        end
        vectors++;
        if (A_input !== 14'h0000) begin
            miscompares++;
            $display("FAIL reset_A_input: got %h, need 0000", A_input);
        end
        vectors++;
        if (coef_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got ready=%b busy=%b done=%b, need 0 0 0",
                     coef_ready, busy, load_done);
        end
        rst = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 16; k++) exp_mem[k] = 14'h0000;
        hold_m = 7'h00;
        // Coefficients offered while IDLE must be ignored.
        coef_valid = 1'b1;
        coef_in = 7'h55;
        repeat (3) step();
        vectors++;
        if (coef_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_flags: got ready=%b busy=%b, need 0 0", coef_ready, busy);
        end
        coef_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            read_word(4'(k), d);
            vectors++;
            if (d !== 14'h0000) begin
                miscompares++;
                $display("FAIL reset_read[%0d]: got %h, need 0000", k, d);
            end
        end
    endtask

    task automatic test_full_load();
        logic [13:0] d;
        pulse_start();
        vectors++;
        if (coef_ready !== 1'b1 || busy !== 1'b1 || load_done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_flags: got ready=%b busy=%b done=%b, need 1 1 0",
                     coef_ready, busy, load_done);
        end
        for (int i = 0; i < 32; i++) begin
            coef_in = 7'(i);
            coef_valid = 1'b1;
            if (i == 31) begin
                vectors++;
                if (load_done !== 1'b0 || coef_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL full_pre_last: got done=%b ready=%b, need 0 1",
                             load_done, coef_ready);
                end
            end
            model_accept(i, 7'(i));
            step();
        end
        coef_valid = 1'b0;
        vectors++;
        if (load_done !== 1'b1 || coef_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done: got done=%b ready=%b busy=%b, need 1 0 0",
                     load_done, coef_ready, busy);
        end
        for (int k = 0; k < 16; k++) begin
            read_word(4'(k), d);
            vectors++;
            if (d !== {7'(2 * k), 7'(2 * k + 1)}) begin
                miscompares++;
                $display("FAIL full_read[%0d]: got %h, need %h", k, d,
                         {7'(2 * k), 7'(2 * k + 1)});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] d;
        int acc = 0;
        int cyc = 0;
        pulse_start();
        while (acc < 32 && cyc < 300) begin
            coef_valid = (cyc % 3 != 1);
            coef_in = coef_valid ? 7'(acc + 40) : 7'h7F;
            vectors++;
            if (load_done !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_early_done: after %0d accepts got done=%b, need 0", acc, load_done);
            end
            if (coef_valid && coef_ready) begin
                model_accept(acc, 7'(acc + 40));
                acc++;
            end
            step();
            cyc++;
        end
        coef_valid = 1'b0;
        vectors++;
        if (acc != 32) begin
            miscompares++;
            $display("FAIL gap_timeout: got %0d accepts, need 32", acc);
        end
        vectors++;
        if (load_done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_done: got done=%b busy=%b, need 1 0", load_done, busy);
        end
        for (int k = 0; k < 16; k++) begin
            read_word(4'(k), d);
            vectors++;
            if (d !== exp_mem[k]) begin
                miscompares++;
                $display("FAIL gap_read[%0d]: got %h, need %h", k, d, exp_mem[k]);
            end
        end
    endtask

    task automatic test_ignored();
        logic [13:0] d;
        // Coefficients offered while DONE must be ignored.
        coef_valid = 1'b1;
        coef_in = 7'h11;
        repeat (3) step();
        vectors++;
        if (coef_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_flags: got ready=%b busy=%b done=%b, need 0 0 1",
                     coef_ready, busy, load_done);
        end
        coef_valid = 1'b0;
        for (int k = 0; k < 16; k += 5) begin
            read_word(4'(k), d);
            vectors++;
            if (d !== exp_mem[k]) begin
                miscompares++;
                $display("FAIL done_read[%0d]: got %h, need %h", k, d, exp_mem[k]);
            end
        end
        // start pulsed at cnt=10 must not restart the count.
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            coef_in = 7'(i + 64);
            coef_valid = 1'b1;
            start = (i == 10);
            if (i >= 30) begin
                vectors++;
                if (load_done !== 1'b0 || coef_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL midstart_pre[%0d]: got done=%b ready=%b, need 0 1",
                             i, load_done, coef_ready);
                end
            end
            model_accept(i, 7'(i + 64));
            step();
        end
        start = 1'b0;
        coef_valid = 1'b0;
        vectors++;
        if (load_done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midstart_done: got done=%b busy=%b, need 1 0", load_done, busy);
        end
        for (int k = 0; k < 16; k++) begin
            read_word(4'(k), d);
            vectors++;
            if (d !== exp_mem[k]) begin
                miscompares++;
                $display("FAIL midstart_read[%0d]: got %h, need %h", k, d, exp_mem[k]);
            end
        end
    endtask

    task automatic test_reload();
        logic [13:0] d;
        logic [13:0] old3;
        old3 = exp_mem[3];
        rom_addr = 4'd3;
        pulse_start();
        vectors++;
        if (load_done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_start: got done=%b busy=%b, need 0 1", load_done, busy);
        end
        for (int i = 0; i < 32; i++) begin
            coef_in = 7'h7F;
            coef_valid = 1'b1;
            model_accept(i, 7'h7F);
            step();
            if (i == 7) begin
                vectors++;
                if (A_input !== old3) begin
                    miscompares++;
                    $display("FAIL rdw_old: got %h, need %h", A_input, old3);
                end
            end
            if (i == 8) begin
                vectors++;
                if (A_input !== 14'h3FFF) begin
                    miscompares++;
                    $display("FAIL rdw_new: got %h, need 3fff", A_input);
                end
            end
        end
        coef_valid = 1'b0;
        vectors++;
        if (load_done !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_done: got %b, need 1", load_done);
        end
        for (int k = 0; k < 16; k++) begin
            read_word(4'(k), d);
            vectors++;
            if (d !== 14'h3FFF) begin
                miscompares++;
                $display("FAIL reload_read[%0d]: got %h, need 3fff", k, d);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [13:0] d;
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            coef_in = 7'(i + 3);
            coef_valid = 1'b1;
            step();
        end
        coef_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (coef_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || A_input !== 14'h0) begin
            miscompares++;
            $display("FAIL midrst_flags: got ready=%b busy=%b done=%b A=%h, need 0 0 0 0000",
                     coef_ready, busy, load_done, A_input);
        end
        for (int k = 0; k < 16; k++) begin
            read_word(4'(k), d);
            vectors++;
            if (d !== 14'h0000) begin
                miscompares++;
                $display("FAIL midrst_read[%0d]: got %h, need 0000", k, d);
            end
        end
        vectors++;
        if (coef_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle: got ready=%b busy=%b, need 0 0", coef_ready, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        coef_valid = 1'b0;
        coef_in = 7'h00;
        rom_addr = 4'h0;
        test_reset();
        test_full_load();
        test_backpressure();
        test_ignored();
        test_reload();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
